clk_edge_monitor: RTL and testbench
===================================

// Module: clk_edge_monitor
// PURPOSE
//   Consumes the divided clock produced by the programmable clock generator and
//   converts it into clean single-cycle rise/fall ticks in the clk_i domain.
//   Measures the divided-clock period in clk_i cycles, reports frequency lock
//   when two consecutive periods match, and flags a lost clock on timeout.
//   Downstream logic uses its ticks as clock enables instead of clocking on the
//   divided clock directly.
// PARAMETERS
//   SYNC_STAGES  2   synchronizer depth on div_clk_i (>=2)
//   CNT_W        16  width of the gap counter, period_o and timeout_i
// PORTS
//   clk_i         in   1      system clock, all logic on rising edge
//   rst_i         in   1      asynchronous, active-high reset
//   en_i          in   1      monitor enable; 0 = forced idle
//   div_clk_i     in   1      divided clock from the generator (async-treated)
//   timeout_i     in   CNT_W  max clk_i cycles between rise events; 0 = no timeout
//   rise_tick_o   out  1      1-cycle pulse per detected rising edge
//   fall_tick_o   out  1      1-cycle pulse per detected falling edge
//   period_o      out  CNT_W  clk_i cycles between last two rise events
//   period_vld_o  out  1      1-cycle pulse when period_o updates
//   lock_o        out  1      two consecutive equal periods seen
//   lost_o        out  1      no rise event within timeout_i cycles
// BEHAVIOUR
// - Reset (async, immediate): all outputs 0, synchronizer/edge flops 0, gap_cnt 0, state IDLE.
// - Synchronizer and edge-detect flop run whenever out of reset, independent of en_i.
// - Edge detect: rise = sync & ~prev, fall = ~sync & prev; ticks registered.
//   Latency: rise_tick_o high on the (SYNC_STAGES+1)th clk_i edge after div_clk_i
//   is first sampled high (3 edges at default). Same for fall_tick_o.
// - en_i=0: next edge -> state IDLE, ticks 0, lock_o 0, lost_o 0, period_vld_o 0,
//   gap_cnt 0; period_o holds. Re-enable never emits a tick for a level that was
//   already stable (prev flop kept tracking).
// - gap_cnt: cleared on a rise event, else +1 per cycle, saturating at all-ones.
//   Measured period = gap_cnt+1 at the rise event, saturating at all-ones.
// - FSM:
//   IDLE: en_i=1 -> ACQ.
//   ACQ:  waits first rise event -> MEAS; gap_cnt cleared; no period_vld; lost_o cleared.
//   MEAS: rise event -> period_o <= measured, period_vld_o pulse; if a previous
//         period exists and measured == period_o -> LOCKED, lock_o 1 next cycle.
//   LOCKED: rise event with measured == period_o -> stay, period_vld_o pulse;
//         mismatch -> period_o updated, period_vld_o pulse, MEAS, lock_o 0.
//   MEAS/LOCKED: timeout_i!=0 and gap_cnt+1 == timeout_i with no rise event ->
//         ACQ, lost_o 1 (sticky until next rise event or en_i=0), lock_o 0,
//         "previous period exists" flag cleared.
// - Simultaneous rise event and timeout in same cycle: rise event wins, no lost.
// - timeout_i changed on the fly: compared each cycle, takes effect immediately.
// - Fall events affect only fall_tick_o; period/lock use rise events only.
// - Ticks are emitted in ACQ/MEAS/LOCKED; suppressed in IDLE.
// TESTING
// 1. Assert rst_i mid-LOCKED, between clk edges -> all outputs 0 immediately, IDLE after release.
// 2. en_i=1, div_clk_i period 8 (generator count 3) -> 1st rise_tick 3 edges after
//    sample; 2nd rise: period_vld_o, period_o=8; 3rd rise: lock_o=1; fall ticks mid-period.
// 3. While locked switch to period 12 -> next rise: period_o=12, lock_o=0; following rise: lock_o=1.
// 4. timeout_i=20, hold div_clk_i low while locked -> lost_o=1, lock_o=0 on 20th gap cycle;
//    restart clock -> lost_o=0 at first rise, no period_vld; relock after 3 rises.
// 5. en_i=0 mid-lock with div_clk_i high, then en_i=1 -> status 0 next cycle, no
//    spurious rise_tick on re-enable; period_o keeps 8.
// 6. timeout_i=0, stop clock >65535 cycles -> no lost_o, gap saturates; restart ->
//    period_o=16'hFFFF with period_vld_o pulse.

Source files
------------

// File: rtl/clk_edge_monitor.sv
// clk_edge_monitor: turns an async divided clock into rise/fall ticks and measures its period, lock and loss
module clk_edge_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             div_clk_i,
  input  logic [CNT_W-1:0] timeout_i,
  output logic             rise_tick_o,
  output logic             fall_tick_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_vld_o,
  output logic             lock_o,
  output logic             lost_o
);
  typedef enum logic [1:0] {IDLE, ACQ, MEAS, LOCKED} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic prev, has_prev;
  logic [CNT_W-1:0] gap_cnt, measured;
  logic [CNT_W:0] gap_p1;
  logic rise, fall, run, tracking, timeout_hit, same, upd;
  // edge events, period arithmetic and next-state selection
  always_comb begin
    rise = sync[SYNC_STAGES-1] & ~prev;
    fall = ~sync[SYNC_STAGES-1] & prev;
    gap_p1 = {1'b0, gap_cnt} + 1'b1;
    measured = &gap_cnt ? gap_cnt : gap_p1[CNT_W-1:0];
    run = en_i && state != IDLE;
    tracking = state == MEAS || state == LOCKED;
    timeout_hit = tracking && !rise && timeout_i != '0 && gap_p1 == {1'b0, timeout_i};
    same = measured == period_o;
    upd = run && rise && tracking;
    state_n = state;
    case (state)
      IDLE:    state_n = ACQ;
      ACQ:     state_n = rise ? MEAS : ACQ;
      MEAS:    state_n = rise ? ((has_prev && same) ? LOCKED : MEAS) : timeout_hit ? ACQ : MEAS;
      LOCKED:  state_n = rise ? (same ? LOCKED : MEAS) : timeout_hit ? ACQ : LOCKED;
      default: state_n = IDLE;
    endcase
    if (!en_i) state_n = IDLE;
  end
  // synchronizer, gap counter, status flags and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      sync <= '0;
      prev <= 1'b0;
      has_prev <= 1'b0;
      gap_cnt <= '0;
      rise_tick_o <= 1'b0;
      fall_tick_o <= 1'b0;
      period_o <= '0;
      period_vld_o <= 1'b0;
      lock_o <= 1'b0;
      lost_o <= 1'b0;
    end else begin
      state <= state_n;
      sync <= {sync[SYNC_STAGES-2:0], div_clk_i};
      prev <= sync[SYNC_STAGES-1];
      has_prev <= (!run || timeout_hit) ? 1'b0 : upd ? 1'b1 : has_prev;
      gap_cnt <= (!run || rise) ? '0 : gap_cnt + {{(CNT_W-1){1'b0}}, ~&gap_cnt};
      rise_tick_o <= run && rise;
      fall_tick_o <= run && fall;
      period_vld_o <= upd;
      if (upd) period_o <= measured;
      lock_o <= state_n == LOCKED;
      lost_o <= (!en_i || rise) ? 1'b0 : timeout_hit ? 1'b1 : lost_o;
    end
  end
endmodule

// File: tb/tb_clk_edge_monitor.sv
// tb_clk_edge_monitor: scenario and randomized checks of clk_edge_monitor against an event-level model
module tb_clk_edge_monitor;
  logic clk_i = 0, rst_i = 1, en_i = 0, div_clk_i = 0;
  logic [15:0] timeout_i = 0;
  logic rise_tick_o, fall_tick_o, period_vld_o, lock_o, lost_o;
  logic [15:0] period_o;
  int checks = 0, failures = 0;
  int hi_len = 4, lo_len = 4, cnt = 0;
  bit stop = 0;

  clk_edge_monitor dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .div_clk_i(div_clk_i), .timeout_i(timeout_i),
    .rise_tick_o(rise_tick_o), .fall_tick_o(fall_tick_o), .period_o(period_o),
    .period_vld_o(period_vld_o), .lock_o(lock_o), .lost_o(lost_o)
  );

  always #5 clk_i = ~clk_i;

  wire [20:0] dut_vec = {rise_tick_o, fall_tick_o, period_vld_o, lock_o, lost_o, period_o};

  // reference model: works on sampled levels, rise times and the list of measured periods
  bit hist[$] = '{0, 0, 0};
  bit on = 0, acq = 0, m_rt = 0, m_ft = 0, m_vld = 0, m_lock = 0, m_lost = 0;
  int nper = 0, m_period = 0;
  longint n = 0, r_prev = 0, meas;
  wire [20:0] exp_vec = {m_rt, m_ft, m_vld, m_lock, m_lost, m_period[15:0]};

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist = '{0, 0, 0};
      {on, acq, m_rt, m_ft, m_vld, m_lock, m_lost} = '0;
      nper = 0; m_period = 0; n = 0; r_prev = 0;
    end else begin
      bit r, f;
      n++;
      r = hist[1] && !hist[2];
      f = !hist[1] && hist[2];
      m_rt = 0; m_ft = 0; m_vld = 0;
      if (!en_i) begin
        on = 0; acq = 0; m_lock = 0; m_lost = 0;
      end else if (!on) begin
        on = 1;
      end else begin
        m_rt = r; m_ft = f;
        if (r) begin
          m_lost = 0;
          if (acq) begin
            meas = (n - r_prev > 65535) ? 65535 : n - r_prev;
            m_vld = 1;
            m_lock = nper > 0 && meas == m_period;
            m_period = int'(meas);
            nper++;
          end else begin
            acq = 1; nper = 0;
          end
          r_prev = n;
        end else if (acq && timeout_i != 0 && n - r_prev == longint'(timeout_i)) begin
          acq = 0; m_lost = 1; m_lock = 0;
        end
      end
      hist.push_front(div_clk_i);
      void'(hist.pop_back());
    end
  end

  // divided-clock generator: advances one clk_i cycle, driven at the falling edge
  task automatic adv();
    if (!stop) begin
      cnt++;
      if (cnt >= (div_clk_i ? hi_len : lo_len)) begin
        div_clk_i = ~div_clk_i;
        cnt = 0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++;
    if (dut_vec !== 21'd0) begin failures++; $display("FAIL reset_init got=%h exp=0", dut_vec); end
    rst_i = 0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (dut_vec !== 21'd0) begin failures++; $display("FAIL idle_after_reset got=%h exp=0", dut_vec); end
  endtask

  task automatic test_lock();
    int first_hi = -1, first_tick = -1;
    hi_len = 4; lo_len = 4; cnt = 0; stop = 0; en_i = 1; timeout_i = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      checks++;
      if (dut_vec !== exp_vec) begin failures++; if (failures < 20) $display("FAIL lock cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
      if (rise_tick_o && first_tick < 0) first_tick = k;
      adv();
      if (div_clk_i && first_hi < 0) first_hi = k;
    end
    checks++;
    if (first_tick - first_hi !== 3) begin failures++; $display("FAIL rise_latency got=%0d exp=3", first_tick - first_hi); end
    checks++;
    if (period_o !== 16'd8 || lock_o !== 1'b1) begin failures++; $display("FAIL lock8 period=%0d lock=%b exp 8/1", period_o, lock_o); end
  endtask

  task automatic test_period_change();
    bit saw_unlock = 0;
    hi_len = 6; lo_len = 6;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_i);
      checks++;
      if (dut_vec !== exp_vec) begin failures++; if (failures < 20) $display("FAIL change cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
      if (!lock_o) saw_unlock = 1;
      adv();
    end
    checks++;
    if (!saw_unlock || period_o !== 16'd12 || lock_o !== 1'b1) begin
      failures++; $display("FAIL relock12 unlock_seen=%b period=%0d lock=%b exp 1/12/1", saw_unlock, period_o, lock_o);
    end
  endtask

  task automatic test_timeout();
    timeout_i = 20;
    for (int k = 0; k < 20 && div_clk_i; k++) begin @(negedge clk_i); adv(); end
    stop = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      checks++;
      if (dut_vec !== exp_vec) begin failures++; if (failures < 20) $display("FAIL timeout cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
    checks++;
    if (lost_o !== 1'b1 || lock_o !== 1'b0) begin failures++; $display("FAIL lost_set lost=%b lock=%b exp 1/0", lost_o, lock_o); end
    stop = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_i);
      checks++;
      if (dut_vec !== exp_vec) begin failures++; if (failures < 20) $display("FAIL restart cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
      adv();
    end
    checks++;
    if (lost_o !== 1'b0 || lock_o !== 1'b1) begin failures++; $display("FAIL relock_after_lost lost=%b lock=%b exp 0/1", lost_o, lock_o); end
  endtask

  task automatic test_disable();
    int ticks = 0;
    hi_len = 4; lo_len = 4; timeout_i = 0;
    for (int k = 0; k < 50; k++) begin @(negedge clk_i); adv(); end
    for (int k = 0; k < 20 && !div_clk_i; k++) begin @(negedge clk_i); adv(); end
    stop = 1;
    repeat (5) @(negedge clk_i);
    checks++;
    if (period_o !== 16'd8 || lock_o !== 1'b1) begin failures++; $display("FAIL pre_disable period=%0d lock=%b exp 8/1", period_o, lock_o); end
    en_i = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      checks++;
      if (dut_vec !== exp_vec) begin failures++; if (failures < 20) $display("FAIL disable cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
    en_i = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      checks++;
      if (dut_vec !== exp_vec) begin failures++; if (failures < 20) $display("FAIL reenable cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
      ticks += rise_tick_o;
    end
    checks++;
    if (ticks != 0 || period_o !== 16'd8 || lock_o !== 1'b0) begin
      failures++; $display("FAIL reenable_status ticks=%0d period=%0d lock=%b exp 0/8/0", ticks, period_o, lock_o);
    end
    stop = 0;
  endtask

  task automatic test_saturate();
    bit saw = 0;
    hi_len = 4; lo_len = 4; timeout_i = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk_i); adv(); end
    for (int k = 0; k < 20 && div_clk_i; k++) begin @(negedge clk_i); adv(); end
    stop = 1;
    for (int k = 0; k < 66000; k++) begin
      @(negedge clk_i);
      checks++;
      if (dut_vec !== exp_vec) begin failures++; if (failures < 20) $display("FAIL stopped cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
    stop = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      checks++;
      if (dut_vec !== exp_vec) begin failures++; if (failures < 20) $display("FAIL sat_restart cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
      if (period_vld_o && period_o === 16'hFFFF) saw = 1;
      adv();
    end
    checks++;
    if (!saw) begin failures++; $display("FAIL saturated_period seen=%b exp=1", saw); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk_i);
      checks++;
      if (dut_vec !== exp_vec) begin failures++; if (failures < 20) $display("FAIL random cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
      if ($urandom_range(149) == 0) en_i = ~en_i;
      if ($urandom_range(299) == 0) timeout_i = $urandom_range(1) ? 16'($urandom_range(40, 5)) : 16'd0;
      if ($urandom_range(99) == 0) begin hi_len = $urandom_range(8, 1); lo_len = $urandom_range(8, 1); end
      if ($urandom_range(249) == 0) stop = ~stop;
      adv();
    end
    stop = 0; en_i = 1;
  endtask

  task automatic test_reset_mid();
    hi_len = 4; lo_len = 4; timeout_i = 0;
    for (int k = 0; k < 50; k++) begin @(negedge clk_i); adv(); end
    checks++;
    if (lock_o !== 1'b1) begin failures++; $display("FAIL pre_reset_lock got=%b exp=1", lock_o); end
    @(negedge clk_i);
    #2 rst_i = 1;
    #1;
    checks++;
    if (dut_vec !== 21'd0) begin failures++; $display("FAIL async_reset got=%h exp=0", dut_vec); end
    @(negedge clk_i);
    rst_i = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_i);
      checks++;
      if (dut_vec !== exp_vec) begin failures++; if (failures < 20) $display("FAIL post_reset cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
      if (k == 0 && dut_vec !== 21'd0) begin failures++; $display("FAIL idle_after_release got=%h exp=0", dut_vec); end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_period_change();
    test_timeout();
    test_disable();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
